// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared tester FSM states and AXI-lite response codes
package sdram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    FIN
  } tester_state_e;

  localparam logic [1:0]  AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXIL_RESP_SLVERR = 2'b10;
  localparam logic [15:0] ERR_COUNT_MAX    = 16'hFFFF;

  // Error counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == ERR_COUNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/taxi_axil_if.sv
// rtl/taxi_axil_if.sv - AXI-lite bundle with initiator and target views
interface taxi_axil_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_tester_pattern.sv
// rtl/axil_tester_pattern.sv - per-word test pattern shared by write and check paths
module axil_tester_pattern #(
  parameter logic [31:0] SEED = 32'h5A5A_C3C3
) (
  input  logic [15:0] idx,
  output logic [31:0] data
);

  // Inverted index in the top half makes stuck/shorted data lines visible.
  assign data = {~idx, idx} ^ SEED;

endmodule

// File: rtl/axil_mem_tester.sv
// rtl/axil_mem_tester.sv - write-then-verify AXI-lite memory tester
module axil_mem_tester
  import sdram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    NUM_WORDS  = 1024,
  parameter logic [31:0]           SEED       = 32'h5A5A_C3C3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  taxi_axil_if.master           m_axil
);

  localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);

  tester_state_e         state_q, state_d;
  logic [15:0]           i_q, i_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [15:0]           err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] first_err_addr_q, first_err_addr_d;
  logic                  err_hit;
  logic [DATA_WIDTH-1:0] pat_data;
  logic [ADDR_WIDTH-1:0] word_addr;

  // Address and pattern depend only on i, so they stay stable while a valid is pending.
  assign word_addr = BASE_ADDR + ADDR_WIDTH'({i_q, 2'b00});

  axil_tester_pattern #(.SEED(SEED)) u_pattern (
    .idx  (i_q),
    .data (pat_data)
  );

  // Next-state logic: sequencing, handshakes and error accounting.
  always_comb begin
    state_d          = state_q;
    i_d              = i_q;
    awvalid_d        = awvalid_q;
    wvalid_d         = wvalid_q;
    bready_d         = bready_q;
    arvalid_d        = arvalid_q;
    rready_d         = rready_q;
    done_d           = 1'b0;
    pass_d           = pass_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    err_hit          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          i_d              = '0;
          err_count_d      = '0;
          first_err_addr_d = '0;
          pass_d           = 1'b0;
          awvalid_d        = 1'b1;
          wvalid_d         = 1'b1;
          state_d          = WR_REQ;
        end
      end
      WR_REQ: begin
        if (m_axil.awready) awvalid_d = 1'b0;
        if (m_axil.wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axil.bvalid) begin
          bready_d = 1'b0;
          err_hit  = (m_axil.bresp != AXIL_RESP_OKAY);
          if (i_q == LAST_IDX) begin
            i_d       = '0;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end else begin
            i_d       = i_q + 16'd1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end
        end
      end
      RD_REQ: begin
        if (m_axil.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axil.rvalid) begin
          rready_d = 1'b0;
          err_hit  = (m_axil.rresp != AXIL_RESP_OKAY) || (m_axil.rdata != pat_data);
          if (i_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            i_d       = i_q + 16'd1;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (err_hit) begin
      if (err_count_q == 16'd0) first_err_addr_d = word_addr;
      err_count_d = sat_inc16(err_count_q);
    end
    // Verdict uses the count including the last word's result.
    if (state_q == RD_RESP && state_d == FIN) pass_d = (err_count_d == 16'd0);
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      i_q              <= '0;
      awvalid_q        <= 1'b0;
      wvalid_q         <= 1'b0;
      bready_q         <= 1'b0;
      arvalid_q        <= 1'b0;
      rready_q         <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
    end else begin
      state_q          <= state_d;
      i_q              <= i_d;
      awvalid_q        <= awvalid_d;
      wvalid_q         <= wvalid_d;
      bready_q         <= bready_d;
      arvalid_q        <= arvalid_d;
      rready_q         <= rready_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;

  assign m_axil.awaddr  = word_addr;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = pat_data;
  assign m_axil.wstrb   = 4'hF;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = word_addr;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;

endmodule

// File: tb/tb_axil_mem_tester.sv
// tb/tb_axil_mem_tester.sv - scoreboard bench for axil_mem_tester
module tb_axil_mem_tester;
  import sdram_pkg::*;

  localparam int NW = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  typedef struct {
    logic [15:0] err;
    logic [31:0] first;
    logic        pass;
  } res_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;

  taxi_axil_if #(.ADDR_W(32), .DATA_W(32)) axil ();

  axil_mem_tester #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BASE_ADDR  (32'h0),
    .NUM_WORDS  (NW),
    .SEED       (32'h5A5A_C3C3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .m_axil         (axil)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_data [NW] = '{32'hA5A5_C3C3, 32'hA5A4_C3C2, 32'hA5A7_C3C1, 32'hA5A6_C3C0};

  wr_exp_t     wr_q [$];
  logic [31:0] rd_q [$];
  res_exp_t    res_q [$];

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  int w_delay = 0;
  bit rand_stall = 1'b0;
  bit bresp_err = 1'b0;
  int corrupt_idx = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got transaction expected none", name);
  endtask

  // Memory slave: drives on the falling edge, knobs shape its timing and errors.
  initial begin : slave
    logic [31:0] mem [NW];
    int          w_wait, ar_wait, ar_delay, r_cnt;
    bit          got_aw, got_w, b_pend, b_hs, r_pend, r_hs;
    logic [31:0] aw_a, w_d, ar_a;
    for (int k = 0; k < NW; k++) mem[k] = '0;
    w_wait = 0; ar_wait = 0; ar_delay = 0; r_cnt = 0;
    got_aw = 0; got_w = 0; b_pend = 0; b_hs = 0; r_pend = 0; r_hs = 0;
    aw_a = '0; w_d = '0; ar_a = '0;
    axil.awready = 1'b0; axil.wready = 1'b0; axil.bvalid = 1'b0; axil.bresp = 2'b00;
    axil.arready = 1'b0; axil.rvalid = 1'b0; axil.rdata = '0; axil.rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        axil.awready = 1'b0; axil.wready = 1'b0; axil.bvalid = 1'b0;
        axil.arready = 1'b0; axil.rvalid = 1'b0;
        w_wait = 0; ar_wait = 0; ar_delay = 0; r_cnt = 0;
        got_aw = 0; got_w = 0; b_pend = 0; b_hs = 0; r_pend = 0; r_hs = 0;
      end else begin
        axil.awready = axil.awvalid;
        if (axil.awvalid) begin got_aw = 1; aw_a = axil.awaddr; end
        axil.wready = axil.wvalid && (w_wait >= w_delay);
        if (axil.wvalid && !axil.wready) w_wait++;
        if (axil.wready) begin got_w = 1; w_d = axil.wdata; w_wait = 0; end
        if (b_hs) begin axil.bvalid = 1'b0; b_hs = 0; end
        if (b_pend) begin
          axil.bvalid = 1'b1;
          axil.bresp  = bresp_err ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
          b_pend = 0;
        end
        if (axil.bvalid && axil.bready) b_hs = 1;
        if (got_aw && got_w) begin
          mem[aw_a[3:2]] = w_d;
          got_aw = 0; got_w = 0; b_pend = 1;
        end
        if (r_hs) begin axil.rvalid = 1'b0; r_hs = 0; end
        if (r_pend) begin
          if (r_cnt > 0) r_cnt--;
          else begin
            axil.rvalid = 1'b1;
            axil.rdata  = mem[ar_a[3:2]] ^ {31'd0, (int'(ar_a[3:2]) == corrupt_idx)};
            axil.rresp  = AXIL_RESP_OKAY;
            r_pend = 0;
          end
        end
        if (axil.rvalid && axil.rready) r_hs = 1;
        axil.arready = axil.arvalid && (ar_wait >= ar_delay);
        if (axil.arvalid && !axil.arready) ar_wait++;
        if (axil.arready) begin
          ar_a = axil.araddr; ar_wait = 0; r_pend = 1;
          ar_delay = rand_stall ? int'($urandom_range(0, 5)) : 0;
          r_cnt    = rand_stall ? int'($urandom_range(0, 5)) : 0;
        end
      end
    end
  end

  // Monitor: samples late in the low phase, pops expectations on each handshake.
  initial begin : monitor
    bit          m_aw, m_w;
    logic [31:0] m_aw_a, m_w_d;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awa, p_wd, p_ara;
    wr_exp_t     we;
    res_exp_t    re;
    logic [31:0] ra;
    m_aw = 0; m_w = 0; m_aw_a = '0; m_w_d = '0;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    p_awa = '0; p_wd = '0; p_ara = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        m_aw = 0; m_w = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
      end else begin
        if (p_awv && !p_awr) chk("aw_hold", axil.awvalid ? axil.awaddr : 32'hDEAD_DEAD, p_awa);
        if (p_wv && !p_wr)   chk("w_hold", axil.wvalid ? axil.wdata : 32'hDEAD_DEAD, p_wd);
        if (p_arv && !p_arr) chk("ar_hold", axil.arvalid ? axil.araddr : 32'hDEAD_DEAD, p_ara);
        if (axil.arvalid)
          chk("ar_exclusive", {29'd0, axil.awvalid, axil.wvalid, axil.bready}, 32'd0);
        if (axil.awvalid && axil.awready) begin
          m_aw = 1; m_aw_a = axil.awaddr;
          chk("awprot", 32'(axil.awprot), 32'd0);
        end
        if (axil.wvalid && axil.wready) begin
          m_w = 1; m_w_d = axil.wdata;
          chk("wstrb", 32'(axil.wstrb), 32'hF);
        end
        if (m_aw && m_w) begin
          m_aw = 0; m_w = 0;
          if (wr_q.size() == 0) unexpected("write");
          else begin
            we = wr_q.pop_front();
            chk("wr_addr", m_aw_a, we.addr);
            chk("wr_data", m_w_d, we.data);
          end
        end
        if (axil.arvalid && axil.arready) begin
          chk("arprot", 32'(axil.arprot), 32'd0);
          if (rd_q.size() == 0) unexpected("read");
          else begin
            ra = rd_q.pop_front();
            chk("rd_addr", axil.araddr, ra);
          end
        end
        if (done) begin
          done_count++;
          chk("done_busy", 32'(busy), 32'd1);
          if (res_q.size() == 0) unexpected("done");
          else begin
            re = res_q.pop_front();
            chk("err_count", 32'(err_count), 32'(re.err));
            chk("first_err_addr", first_err_addr, re.first);
            chk("pass", 32'(pass), 32'(re.pass));
          end
        end
        p_awv = axil.awvalid; p_awr = axil.awready; p_awa = axil.awaddr;
        p_wv  = axil.wvalid;  p_wr  = axil.wready;  p_wd  = axil.wdata;
        p_arv = axil.arvalid; p_arr = axil.arready; p_ara = axil.araddr;
      end
    end
  end

  task automatic push_txns();
    for (int k = 0; k < NW; k++) begin
      wr_q.push_back('{addr: 32'(4 * k), data: exp_data[k]});
      rd_q.push_back(32'(4 * k));
    end
  endtask

  task automatic push_result(input logic [15:0] e_err, input logic [31:0] e_first, input logic e_pass);
    res_q.push_back('{err: e_err, first: e_first, pass: e_pass});
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_count < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(done_count >= target), 32'd1);
    repeat (3) @(negedge clk);
    chk({name, "_wr_q"}, 32'(wr_q.size()), 32'd0);
    chk({name, "_rd_q"}, 32'(rd_q.size()), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_pass"}, 32'(pass), 32'd0);
    chk({name, "_err"}, 32'(err_count), 32'd0);
    chk({name, "_first"}, first_err_addr, 32'd0);
    chk({name, "_valids"}, {27'd0, axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready}, 32'd0);
  endtask

  initial begin : stimulus
    int n;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    push_txns(); push_result(16'd0, 32'h0, 1'b1);
    pulse_start();
    wait_done(1, "t1_done");

    corrupt_idx = 2;
    push_txns(); push_result(16'd1, 32'h8, 1'b0);
    pulse_start();
    wait_done(2, "t2_done");
    corrupt_idx = -1;

    bresp_err = 1'b1;
    push_txns(); push_result(16'd4, 32'h0, 1'b0);
    pulse_start();
    wait_done(3, "t3_done");
    bresp_err = 1'b0;

    w_delay = 3; rand_stall = 1'b1;
    push_txns(); push_result(16'd0, 32'h0, 1'b1);
    pulse_start();
    wait_done(4, "t4_done");
    w_delay = 0; rand_stall = 1'b0;

    corrupt_idx = 0;
    push_txns();
    pulse_start();
    n = 0;
    while (!(axil.arvalid && axil.araddr == 32'h8) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_word2", 32'(axil.arvalid && axil.araddr == 32'h8), 32'd1);
    chk("t5_err_before_rst", 32'(err_count), 32'd1);
    #1 rst = 1'b1;
    #1 check_idle_outputs("t5_async_rst");
    wr_q.delete(); rd_q.delete();
    corrupt_idx = -1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    chk("t5_no_done", 32'(done_count), 32'd4);
    push_txns(); push_result(16'd0, 32'h0, 1'b1);
    pulse_start();
    wait_done(5, "t5_rerun_done");

    push_txns(); push_result(16'd0, 32'h0, 1'b1);
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    wait_done(6, "t6_done");
    repeat (50) @(negedge clk);
    chk("t6_single_done", 32'(done_count), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
